// File: rtl/filter_bank_pkg.sv
// Shared types and constants for the matched-filter bank sequencer.
//   state_t          : sequencer states
//   RAM_READ_LATENCY : cycles from capture-buffer address issue to data
//   score_t          : default-width unsigned match score
//   clog2_min1       : $clog2 clamped to a minimum of 1 bit
package filter_bank_pkg;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      CAPTURE = 3'd1,
      STREAM  = 3'd2,
      FLUSH   = 3'd3,
      SELECT  = 3'd4,
      REPORT  = 3'd5
   } state_t;

   localparam int unsigned RAM_READ_LATENCY = 2;
   localparam int unsigned SCORE_W          = 32;

   typedef logic [SCORE_W-1:0] score_t;

   function automatic int unsigned clog2_min1(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/filter_bank_controller_peak_tracker.sv
// Per-filter running maximum of an unsigned score stream.
//   clk, rst_n : clock, synchronous active-low reset
//   clear      : zero the peak (wins over valid)
//   valid      : score is presented this cycle
//   score      : unsigned score
//   peak       : largest score seen since the last clear
module peak_tracker #(
   parameter int unsigned W = 32
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         clear,
   input  logic         valid,
   input  logic [W-1:0] score,
   output logic [W-1:0] peak
);

   always_ff @(posedge clk) begin
      if (!rst_n)                      peak <= '0;
      else if (clear)                  peak <= '0;
      else if (valid && score > peak)  peak <= score;
   end

endmodule

// File: rtl/filter_bank_controller.sv
// Sequencer for a bank of matched filters: loads fingerprints, captures a
// sample block, replays it to all filters for N passes, tracks per-filter peak
// scores and reports the winner over a valid/ready handshake.
//   fingerprint load : load_axiiv/load_axiid/load_axiready -> coef_we/addr/data
//   capture          : trigger, axiiv/axiid, num_passes, threshold, abort
//   filter drive     : filt_axiov/filt_axiod, score_axiiv/score_axiid
//   result           : result_axiov/ready/index/score/hit, busy
// FLUSH_CYCLES must be >= RAM_READ_LATENCY: the next pass's first reads are
// issued inside FLUSH so the gap between bursts is exactly FLUSH_CYCLES.
module filter_bank_controller
   import filter_bank_pkg::*;
#(
   parameter int unsigned SAMPLE_DATA_WIDTH = 8,
   parameter int unsigned CAPTURE_LENGTH    = 1000,
   parameter int unsigned NUM_FILTERS       = 4,
   parameter int unsigned MATCH_SCORE_WIDTH = 32,
   parameter int unsigned PASS_WIDTH        = 12,
   parameter int unsigned FLUSH_CYCLES      = 2
) (
   input  logic                                     clk,
   input  logic                                     rst_n,
   input  logic                                     trigger,
   input  logic                                     abort,
   input  logic [PASS_WIDTH-1:0]                    num_passes,
   input  logic [MATCH_SCORE_WIDTH-1:0]             threshold,
   input  logic                                     axiiv,
   input  logic [SAMPLE_DATA_WIDTH-1:0]             axiid,
   input  logic                                     load_axiiv,
   input  logic [7:0]                               load_axiid,
   output logic                                     load_axiready,
   output logic [NUM_FILTERS-1:0]                   coef_we,
   output logic [clog2_min1(CAPTURE_LENGTH)-1:0]    coef_addr,
   output logic [SAMPLE_DATA_WIDTH-1:0]             coef_data,
   output logic                                     filt_axiov,
   output logic [SAMPLE_DATA_WIDTH-1:0]             filt_axiod,
   input  logic [NUM_FILTERS-1:0]                   score_axiiv,
   input  logic [NUM_FILTERS*MATCH_SCORE_WIDTH-1:0] score_axiid,
   output logic                                     result_axiov,
   input  logic                                     result_axiready,
   output logic [clog2_min1(NUM_FILTERS)-1:0]       result_index,
   output logic [MATCH_SCORE_WIDTH-1:0]             result_score,
   output logic                                     result_hit,
   output logic                                     busy
);

   localparam int unsigned AW  = clog2_min1(CAPTURE_LENGTH);
   localparam int unsigned RAW = AW + 2;
   localparam int unsigned IW  = clog2_min1(NUM_FILTERS);
   localparam int unsigned FW  = $clog2(NUM_FILTERS + 1);
   localparam int unsigned CW  = clog2_min1(FLUSH_CYCLES);
   localparam int unsigned PW  = PASS_WIDTH + 1;
   localparam int unsigned W   = MATCH_SCORE_WIDTH;
   localparam int unsigned DW  = SAMPLE_DATA_WIDTH;

   state_t           state;
   logic [AW-1:0]    wa;
   logic [RAW-1:0]   ra;
   logic [CW-1:0]    fc;
   logic [PW-1:0]    pass;
   logic [PW-1:0]    eff_passes;
   logic [W-1:0]     thr;
   logic [AW-1:0]    la;
   logic [FW-1:0]    lf;
   logic [IW-1:0]    sel;
   logic [W-1:0]     best_score;
   logic [IW-1:0]    best_idx;
   logic [W-1:0]     peak [NUM_FILTERS];
   logic [W-1:0]     snap [NUM_FILTERS];
   logic [DW-1:0]    mem  [CAPTURE_LENGTH];
   logic [DW-1:0]    rd1;
   logic             rd_v1;
   logic             issue_v;
   logic [AW-1:0]    issue_addr;
   logic             cap_we;
   logic             peak_clear;
   logic             sel_better;
   logic [W-1:0]     win_score;

   // Read issue: main burst in STREAM, plus head-of-next-pass prefetch in FLUSH
   always_comb begin
      issue_v    = 1'b0;
      issue_addr = '0;
      if (state == STREAM && ra < RAW'(CAPTURE_LENGTH)) begin
         issue_v    = 1'b1;
         issue_addr = AW'(ra);
      end else if (state == FLUSH && pass < eff_passes &&
                   32'(fc) + RAM_READ_LATENCY >= FLUSH_CYCLES) begin
         issue_v    = 1'b1;
         issue_addr = AW'(32'(fc) + RAM_READ_LATENCY - FLUSH_CYCLES);
      end
      cap_we     = (state == CAPTURE) && axiiv;
      peak_clear = (state == IDLE) && trigger && !abort;
      sel_better = snap[sel] > best_score;
      win_score  = sel_better ? snap[sel] : best_score;
   end

   // Capture buffer; second latency stage is rd1 -> filt_axiod
   always_ff @(posedge clk) begin
      if (cap_we) mem[wa] <= axiid;
      rd1 <= mem[issue_addr];
   end

   for (genvar i = 0; i < NUM_FILTERS; i++) begin : g_peak
      peak_tracker #(.W(W)) u_peak (
         .clk   (clk),
         .rst_n (rst_n),
         .clear (peak_clear),
         .valid (score_axiiv[i] && (state != IDLE)),
         .score (score_axiid[i*W +: W]),
         .peak  (peak[i])
      );
   end

   // Sequencer, fingerprint loader and output registers
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state         <= IDLE;
         load_axiready <= 1'b1;
         busy          <= 1'b0;
         coef_we       <= '0;
         coef_addr     <= '0;
         coef_data     <= '0;
         la            <= '0;
         lf            <= '0;
         filt_axiov    <= 1'b0;
         filt_axiod    <= '0;
         rd_v1         <= 1'b0;
         result_axiov  <= 1'b0;
         result_index  <= '0;
         result_score  <= '0;
         result_hit    <= 1'b0;
         wa            <= '0;
         ra            <= '0;
         fc            <= '0;
         pass          <= '0;
         eff_passes    <= '0;
         thr           <= '0;
         sel           <= '0;
         best_score    <= '0;
         best_idx      <= '0;
         for (int i = 0; i < NUM_FILTERS; i++) snap[i] <= '0;
      end else begin
         // Fingerprint load: walks (filter, addr) once, then drops bytes
         coef_we <= '0;
         if (load_axiiv && load_axiready && lf < FW'(NUM_FILTERS)) begin
            coef_we   <= NUM_FILTERS'(1) << lf;
            coef_addr <= la;
            coef_data <= DW'(load_axiid);
            if (la == AW'(CAPTURE_LENGTH - 1)) begin
               la <= '0;
               lf <= lf + 1'b1;
            end else begin
               la <= la + 1'b1;
            end
         end

         rd_v1      <= issue_v && !abort;
         filt_axiov <= rd_v1 && !abort;
         if (rd_v1) filt_axiod <= rd1;

         if (abort && state != IDLE) begin
            state         <= IDLE;
            busy          <= 1'b0;
            load_axiready <= 1'b1;
            result_axiov  <= 1'b0;
         end else begin
            case (state)
               IDLE: begin
                  if (trigger && !abort) begin
                     state         <= CAPTURE;
                     busy          <= 1'b1;
                     load_axiready <= 1'b0;
                     wa            <= '0;
                     eff_passes    <= (num_passes == '0) ? PW'(1) : PW'(num_passes);
                     thr           <= threshold;
                  end
               end
               CAPTURE: begin
                  if (axiiv) begin
                     if (wa == AW'(CAPTURE_LENGTH - 1)) begin
                        state <= STREAM;
                        ra    <= '0;
                        pass  <= '0;
                        wa    <= '0;
                     end else begin
                        wa <= wa + 1'b1;
                     end
                  end
               end
               STREAM: begin
                  ra <= ra + 1'b1;
                  // Leave once the last sample of the pass is on filt_axiod
                  if (ra == RAW'(CAPTURE_LENGTH + RAM_READ_LATENCY - 1)) begin
                     state <= FLUSH;
                     fc    <= '0;
                     pass  <= pass + 1'b1;
                  end
               end
               FLUSH: begin
                  fc <= fc + 1'b1;
                  if (fc == CW'(FLUSH_CYCLES - 1)) begin
                     if (pass < eff_passes) begin
                        state <= STREAM;
                        ra    <= RAW'(RAM_READ_LATENCY);
                     end else begin
                        state      <= SELECT;
                        sel        <= '0;
                        best_score <= '0;
                        best_idx   <= '0;
                        snap       <= peak;
                     end
                  end
               end
               SELECT: begin
                  // Strict compare keeps the lowest index on ties
                  if (sel_better) begin
                     best_score <= snap[sel];
                     best_idx   <= sel;
                  end
                  sel <= sel + 1'b1;
                  if (sel == IW'(NUM_FILTERS - 1)) begin
                     state        <= REPORT;
                     result_axiov <= 1'b1;
                     result_index <= sel_better ? sel : best_idx;
                     result_score <= win_score;
                     result_hit   <= win_score >= thr;
                  end
               end
               REPORT: begin
                  if (result_axiready) begin
                     state         <= IDLE;
                     result_axiov  <= 1'b0;
                     busy          <= 1'b0;
                     load_axiready <= 1'b1;
                  end
               end
               default: begin
                  state         <= IDLE;
                  busy          <= 1'b0;
                  load_axiready <= 1'b1;
                  result_axiov  <= 1'b0;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_filter_bank_controller.sv
// Randomized self-checking bench for filter_bank_controller with a
// transaction-level reference model (expected byte walk, replayed bursts,
// peak maxima and winner selection).
module tb_filter_bank_controller;
   import filter_bank_pkg::*;

   localparam int unsigned SDW = 8;
   localparam int unsigned CL  = 1000;
   localparam int unsigned NF  = 4;
   localparam int unsigned SW  = 32;
   localparam int unsigned PW  = 12;
   localparam int unsigned FC  = 2;

   logic             clk = 1'b0;
   logic             rst_n;
   logic             trigger, abort;
   logic [PW-1:0]    num_passes;
   logic [SW-1:0]    threshold;
   logic             axiiv;
   logic [SDW-1:0]   axiid;
   logic             load_axiiv;
   logic [7:0]       load_axiid;
   logic             load_axiready;
   logic [NF-1:0]    coef_we;
   logic [9:0]       coef_addr;
   logic [SDW-1:0]   coef_data;
   logic             filt_axiov;
   logic [SDW-1:0]   filt_axiod;
   logic [NF-1:0]    score_axiiv;
   logic [NF*SW-1:0] score_axiid;
   logic             result_axiov, result_axiready;
   logic [1:0]       result_index;
   logic [SW-1:0]    result_score;
   logic             result_hit, busy;

   always #5 clk = ~clk;

   filter_bank_controller #(
      .SAMPLE_DATA_WIDTH(SDW), .CAPTURE_LENGTH(CL), .NUM_FILTERS(NF),
      .MATCH_SCORE_WIDTH(SW), .PASS_WIDTH(PW), .FLUSH_CYCLES(FC)
   ) dut (
      .clk(clk), .rst_n(rst_n), .trigger(trigger), .abort(abort),
      .num_passes(num_passes), .threshold(threshold),
      .axiiv(axiiv), .axiid(axiid),
      .load_axiiv(load_axiiv), .load_axiid(load_axiid), .load_axiready(load_axiready),
      .coef_we(coef_we), .coef_addr(coef_addr), .coef_data(coef_data),
      .filt_axiov(filt_axiov), .filt_axiod(filt_axiod),
      .score_axiiv(score_axiiv), .score_axiid(score_axiid),
      .result_axiov(result_axiov), .result_axiready(result_axiready),
      .result_index(result_index), .result_score(result_score),
      .result_hit(result_hit), .busy(busy)
   );

   int          checks   = 0;
   int          failures = 0;
   int unsigned load_sent;
   logic [SDW-1:0] cap [CL];
   score_t      mpeak [NF];

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         if (failures <= 40) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic reset_dut();
      @(negedge clk);
      rst_n = 1'b0; trigger = 1'b0; abort = 1'b0; num_passes = '0; threshold = '0;
      axiiv = 1'b0; axiid = '0; load_axiiv = 1'b0; load_axiid = '0;
      score_axiiv = '0; score_axiid = '0; result_axiready = 1'b0;
      @(negedge clk);
      load_sent = 0;
   endtask

   task automatic check_reset_outputs(input string pfx);
      check({pfx, "_load_ready"}, load_axiready, 1);
      check({pfx, "_busy"},       busy, 0);
      check({pfx, "_coef_we"},    coef_we, 0);
      check({pfx, "_coef_addr"},  coef_addr, 0);
      check({pfx, "_coef_data"},  coef_data, 0);
      check({pfx, "_filt_v"},     filt_axiov, 0);
      check({pfx, "_filt_d"},     filt_axiod, 0);
      check({pfx, "_res_v"},      result_axiov, 0);
      check({pfx, "_res_idx"},    result_index, 0);
      check({pfx, "_res_score"},  result_score, 0);
      check({pfx, "_res_hit"},    result_hit, 0);
   endtask

   // Byte k of the load stream lands at filter k/CL, address k%CL, one cycle later
   task automatic load_bytes(input int unsigned n);
      logic [NF-1:0] exp_we;
      for (int unsigned i = 0; i < n; i++) begin
         if ($urandom_range(0, 3) == 0) begin
            load_axiiv = 1'b0;
            @(negedge clk);
            check("coef_we_idle", coef_we, 0);
         end
         load_axiiv = 1'b1;
         load_axiid = 8'(load_sent % 256);
         @(negedge clk);
         if (load_sent < NF * CL) begin
            exp_we = '0;
            exp_we[load_sent / CL] = 1'b1;
            check("coef_we",   coef_we, exp_we);
            check("coef_addr", coef_addr, load_sent % CL);
            check("coef_data", coef_data, load_sent % 256);
         end else begin
            check("coef_we_dropped", coef_we, 0);
         end
         load_sent++;
      end
      load_axiiv = 1'b0;
   endtask

   task automatic send_samples(input int unsigned n, input bit seq, input bit load_noise);
      for (int unsigned i = 0; i < n; i++) begin
         result_axiready = 1'($urandom_range(0, 1));
         if ($urandom_range(0, 3) == 0) begin
            axiiv = 1'b0;
            @(negedge clk);
         end
         axiiv  = 1'b1;
         axiid  = seq ? SDW'(i % 256) : SDW'($urandom);
         cap[i] = axiid;
         if (load_noise) begin
            load_axiiv = 1'b1;
            load_axiid = 8'($urandom);
         end
         @(negedge clk);
         if (load_noise) check("coef_we_while_busy", coef_we, 0);
      end
      axiiv = 1'b0;
      load_axiiv = 1'b0;
      result_axiready = 1'b0;
   endtask

   task automatic drive_scores(input bit active, input bit fixed, input int kg);
      score_t v;
      score_axiiv = '0;
      score_axiid = '0;
      if (!active) return;
      if (fixed) begin
         if (kg == 10) begin
            score_axiiv = '1;
            score_axiid = {32'd12, 32'd90, 32'd90, 32'd5};
         end
      end else if ($urandom_range(0, 7) == 0) begin
         for (int i = 0; i < NF; i++) begin
            if ($urandom_range(0, 1) == 1) begin
               v = ($urandom_range(0, 9) == 0) ? score_t'($urandom) : score_t'($urandom_range(0, 200));
               score_axiiv[i] = 1'b1;
               score_axiid[i*SW +: SW] = v;
            end
         end
      end
      for (int i = 0; i < NF; i++)
         if (score_axiiv[i] && score_axiid[i*SW +: SW] > mpeak[i]) mpeak[i] = score_axiid[i*SW +: SW];
   endtask

   // Trigger, capture, replay and handshake one full result
   task automatic run_pass_test(input int unsigned npass, input bit fixed, input bit seq,
                                input bit load_noise, input int unsigned hold);
      int unsigned eff;
      int          waited;
      score_t      thr, mx, exp_score;
      int          exp_idx;
      eff = (npass == 0) ? 1 : npass;
      thr = fixed ? score_t'(50) : (($urandom_range(0, 1) == 1) ? score_t'($urandom) : score_t'($urandom_range(0, 220)));
      for (int i = 0; i < NF; i++) mpeak[i] = '0;
      num_passes = PW'(npass);
      threshold  = thr;
      trigger    = 1'b1;
      @(negedge clk);
      trigger    = 1'b0;
      num_passes = PW'($urandom);
      threshold  = SW'($urandom);
      check("busy_after_trigger", busy, 1);
      check("load_ready_busy", load_axiready, 0);
      send_samples(CL, seq, load_noise);

      waited = 0;
      while (filt_axiov !== 1'b1 && waited < 10) begin
         @(negedge clk);
         waited++;
      end
      check("burst_start", filt_axiov, 1);
      for (int unsigned p = 0; p < eff; p++) begin
         for (int unsigned k = 0; k < CL; k++) begin
            check("burst_valid", filt_axiov, 1);
            check("burst_data", filt_axiod, cap[k]);
            drive_scores(1'b1, fixed, int'(p * CL + k));
            trigger = (p == 0 && k == 500);
            @(negedge clk);
         end
         if (p + 1 < eff) begin
            for (int g = 0; g < FC; g++) begin
               check("gap_low", filt_axiov, 0);
               drive_scores(1'b1, fixed, -1);
               @(negedge clk);
            end
         end
      end
      drive_scores(1'b0, fixed, -1);

      waited = 0;
      while (result_axiov !== 1'b1 && waited < 40) begin
         check("no_extra_burst", filt_axiov, 0);
         @(negedge clk);
         waited++;
      end
      check("result_valid", result_axiov, 1);

      mx = '0;
      for (int i = 0; i < NF; i++) if (mpeak[i] > mx) mx = mpeak[i];
      exp_idx = 0;
      for (int i = NF - 1; i >= 0; i--) if (mpeak[i] == mx) exp_idx = i;
      exp_score = mx;
      for (int unsigned h = 0; h <= hold; h++) begin
         check("result_index", result_index, exp_idx);
         check("result_score", result_score, exp_score);
         check("result_hit",   result_hit, exp_score >= thr);
         check("result_hold_valid", result_axiov, 1);
         @(negedge clk);
      end
      result_axiready = 1'b1;
      @(negedge clk);
      result_axiready = 1'b0;
      check("result_done_valid", result_axiov, 0);
      check("result_done_busy", busy, 0);
      check("result_done_load_ready", load_axiready, 1);
   endtask

   task automatic abort_test();
      int waited;
      num_passes = PW'(3);
      threshold  = '0;
      trigger    = 1'b1;
      @(negedge clk);
      trigger = 1'b0;
      send_samples(CL, 1'b0, 1'b0);
      waited = 0;
      while (filt_axiov !== 1'b1 && waited < 10) begin
         @(negedge clk);
         waited++;
      end
      for (int k = 0; k < 100; k++) begin
         check("abort_pre_data", filt_axiod, cap[k]);
         @(negedge clk);
      end
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      check("abort_filt_v", filt_axiov, 0);
      check("abort_busy", busy, 0);
      check("abort_load_ready", load_axiready, 1);
      for (int k = 0; k < 30; k++) begin
         check("abort_no_result", result_axiov, 0);
         check("abort_no_filt", filt_axiov, 0);
         @(negedge clk);
      end
   endtask

   initial begin
      #3_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      reset_dut();
      rst_n = 1'b1;
      check_reset_outputs("reset");

      load_bytes(500);
      run_pass_test(0, 1'b0, 1'b1, 1'b1, 3);
      load_bytes(NF * CL + 1 - 500);

      run_pass_test(3, 1'b1, 1'b1, 1'b0, 20);

      abort_test();
      run_pass_test(2, 1'b0, 1'b0, 1'b0, 2);
      run_pass_test(1, 1'b0, 1'b0, 1'b0, 1);

      // Synchronous reset in the middle of a capture
      num_passes = PW'(1);
      trigger = 1'b1;
      @(negedge clk);
      trigger = 1'b0;
      send_samples(300, 1'b1, 1'b0);
      reset_dut();
      check_reset_outputs("reset_mid_capture");
      rst_n = 1'b1;
      @(negedge clk);
      load_bytes(1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
